// File: rtl/inst_queue_if.sv
// inst_queue_if: program control, instruction-memory read port and FIFO head port of inst_queue
interface inst_queue_if #(
  parameter int INST_LEN      = 256,
  parameter int INST_ADDR_LEN = 16,
  parameter int CNT_LEN       = 16
);
  logic                     start;
  logic [INST_ADDR_LEN-1:0] st_addr;
  logic [CNT_LEN-1:0]       inst_num;
  logic                     busy;
  logic                     done;
  logic                     err_ovf;
  logic                     im_rd_en;
  logic [INST_ADDR_LEN-1:0] im_rd_addr;
  logic                     im_rd_valid;
  logic [INST_LEN-1:0]      im_rd_data;
  logic [INST_LEN-1:0]      instruct;
  logic                     inst_empty;
  logic                     inst_req;
  modport slave (
    input  start, st_addr, inst_num, im_rd_valid, im_rd_data, inst_req,
    output busy, done, err_ovf, im_rd_en, im_rd_addr, instruct, inst_empty
  );
  modport master (
    output start, st_addr, inst_num, im_rd_valid, im_rd_data, inst_req,
    input  busy, done, err_ovf, im_rd_en, im_rd_addr, instruct, inst_empty
  );
endinterface

// File: rtl/inst_queue.sv
// inst_queue: credit-limited instruction fetcher feeding a first-word-fall-through instruction FIFO
module inst_queue #(
  parameter int INST_LEN      = 256,
  parameter int INST_ADDR_LEN = 16,
  parameter int DEPTH_LOG2    = 4,
  parameter int CNT_LEN       = 16
) (
  input logic        clk,
  input logic        rst,
  inst_queue_if.slave io_q
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW = DEPTH_LOG2 + 1;
  localparam int CW = DEPTH_LOG2 + 2;
  localparam logic [1:0] S_IDLE = 2'd0, S_FETCH = 2'd1, S_DRAIN = 2'd2;
  logic [1:0]               r_state;
  logic [INST_ADDR_LEN-1:0] r_addr;
  logic [CNT_LEN-1:0]       r_rem;
  logic [PW-1:0]            r_cnt, r_outst;
  logic [DEPTH_LOG2-1:0]    r_wp, r_rp;
  logic [INST_LEN-1:0]      r_mem [DEPTH];
  logic [INST_LEN-1:0]      r_head;
  logic                     r_done, r_err;
  logic [CW-1:0]            w_credit;
  logic                     w_issue, w_push, w_pop, w_go, w_drained;
  logic [PW-1:0]            w_cnt_left;
  logic [DEPTH_LOG2-1:0]    w_rp_nxt;
  logic [INST_LEN-1:0]      w_head_nxt;
  // entries held plus reads in flight can never exceed the FIFO, so pushes always find room
  assign w_credit   = {1'b0, r_cnt} + {1'b0, r_outst};
  assign w_issue    = r_state == S_FETCH && r_rem != '0 && w_credit < CW'(DEPTH);
  assign w_push     = io_q.im_rd_valid && r_outst != '0;
  assign w_pop      = io_q.inst_req && r_cnt != '0;
  assign w_go       = r_state == S_IDLE && io_q.start;
  assign w_drained  = r_state == S_DRAIN && r_outst == '0 && r_cnt == '0;
  assign w_cnt_left = r_cnt - PW'(w_pop);
  assign w_rp_nxt   = r_rp + DEPTH_LOG2'(w_pop);
  // head register: next stored entry, else the word arriving into an empty FIFO, else hold
  assign w_head_nxt = w_cnt_left != '0 ? r_mem[w_rp_nxt] : w_push ? io_q.im_rd_data : r_head;
  assign io_q.busy       = r_state != S_IDLE;
  assign io_q.done       = r_done;
  assign io_q.err_ovf    = r_err;
  assign io_q.im_rd_en   = w_issue;
  assign io_q.im_rd_addr = r_addr;
  assign io_q.instruct   = r_head;
  assign io_q.inst_empty = r_cnt == '0;
  // sequencer: program latch, address/remaining counters, read credit and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_outst <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done  <= (w_go && io_q.inst_num == '0) || w_drained;
      r_err   <= r_err || (io_q.im_rd_valid && r_outst == '0);
      r_outst <= r_outst + PW'(w_issue) - PW'(w_push);
      if (w_go && io_q.inst_num != '0) begin
        r_addr  <= io_q.st_addr;
        r_rem   <= io_q.inst_num;
        r_state <= S_FETCH;
      end else if (w_issue) begin
        r_addr <= r_addr + 1'b1;
        r_rem  <= r_rem - 1'b1;
        if (r_rem == CNT_LEN'(1)) r_state <= S_DRAIN;
      end else if (w_drained) r_state <= S_IDLE;
    end
  end
  // FIFO bookkeeping: occupancy, pointers and registered head
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_head <= '0;
    end else begin
      r_cnt  <= w_cnt_left + PW'(w_push);
      r_wp   <= r_wp + DEPTH_LOG2'(w_push);
      r_rp   <= w_rp_nxt;
      r_head <= w_head_nxt;
    end
  end
  // FIFO storage, written on every accepted return
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= io_q.im_rd_data;
  end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed tests of inst_queue against a queue-based reference model
module tb_inst_queue;
  localparam int IL = 256, AL = 16, DL = 2, CL = 16, DEPTH = 4;
  logic clk = 1'b0, rst = 1'b1, stray = 1'b0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  inst_queue_if #(.INST_LEN(IL), .INST_ADDR_LEN(AL), .CNT_LEN(CL)) q ();
  inst_queue #(.INST_LEN(IL), .INST_ADDR_LEN(AL), .DEPTH_LOG2(DL), .CNT_LEN(CL)) dut (
    .clk(clk), .rst(rst), .io_q(q)
  );
  function automatic logic [IL-1:0] word(input logic [AL-1:0] a);
    return {16{a ^ 16'hC3A5}};
  endfunction
  task automatic chk(input string nm, input logic [IL-1:0] act, input logic [IL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask
  // instruction memory: fixed two-cycle latency, in-flight reads lost on reset
  logic s1v = 1'b0, s2v = 1'b0;
  logic [AL-1:0] s1a = '0, s2a = '0;
  always @(posedge clk) begin
    if (rst) begin
      s1v <= 1'b0;
      s2v <= 1'b0;
    end else begin
      s1v <= q.im_rd_en;
      s1a <= q.im_rd_addr;
      s2v <= s1v;
      s2a <= s1a;
    end
  end
  assign q.im_rd_valid = s2v | stray;
  assign q.im_rd_data  = word(s2a);
  // reference model: checks outputs, then predicts the state after the coming edge
  logic [IL-1:0] mq[$];
  logic [IL-1:0] m_head = '0;
  logic [AL-1:0] m_addr = '0;
  int m_outst = 0, m_rem = 0;
  bit m_act = 0, m_fetch = 0, m_done = 0, m_err = 0, armed = 0;
  always @(negedge clk) begin : model
    bit en, push, pop, idle, drain_done;
    en = m_fetch && m_rem > 0 && (mq.size() + m_outst) < DEPTH;
    if (armed) begin
      chk("busy", q.busy, m_act);
      chk("done", q.done, m_done);
      chk("err_ovf", q.err_ovf, m_err);
      chk("im_rd_en", q.im_rd_en, en);
      chk("im_rd_addr", q.im_rd_addr, m_addr);
      chk("inst_empty", q.inst_empty, mq.size() == 0);
      chk("instruct", q.instruct, m_head);
    end
    if (rst) begin
      mq.delete();
      m_head = '0; m_addr = '0; m_outst = 0; m_rem = 0;
      m_act = 0; m_fetch = 0; m_done = 0; m_err = 0; armed = 1;
    end else begin
      idle = !m_act;
      push = q.im_rd_valid && m_outst > 0;
      pop = q.inst_req && mq.size() > 0;
      drain_done = m_act && !m_fetch && m_outst == 0 && mq.size() == 0;
      m_err = m_err || (q.im_rd_valid && m_outst == 0);
      m_done = drain_done || (idle && q.start && q.inst_num == 0);
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(q.im_rd_data);
      m_outst = m_outst + int'(en) - int'(push);
      if (drain_done) m_act = 0;
      if (en) begin
        m_addr = m_addr + 1'b1;
        m_rem--;
        if (m_rem == 0) m_fetch = 0;
      end else if (idle && q.start && q.inst_num != 0) begin
        m_act = 1; m_fetch = 1; m_addr = q.st_addr; m_rem = int'(q.inst_num);
      end
      if (mq.size() > 0) m_head = mq[0];
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic prog(input logic [AL-1:0] a, input logic [CL-1:0] n);
    q.st_addr = a; q.inst_num = n; q.start = 1'b1;
    tick();
    q.start = 1'b0;
  endtask
  task automatic drain();
    bit seen = 0;
    q.inst_req = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = q.done;
      tick();
    end
    q.inst_req = 1'b0;
    chk("drain_done_seen", seen, 1);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n;
    logic [AL-1:0] got[$];
    logic [AL-1:0] ex [4];
    ex = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    q.start = 0; q.st_addr = '0; q.inst_num = '0; q.inst_req = 0;
    tick(2);
    rst = 0;
    @(negedge clk);
    chk("rst_empty", q.inst_empty, 1);
    chk("rst_instruct", q.instruct, '0);
    tick();
    // T1/T2: three words, then pop them two cycles apart
    prog(16'h0010, 3);
    @(negedge clk); chk("t1_en0", q.im_rd_en, 1); chk("t1_addr0", q.im_rd_addr, 16'h0010);
    tick(); @(negedge clk); chk("t1_addr1", q.im_rd_addr, 16'h0011);
    tick(); @(negedge clk); chk("t1_addr2", q.im_rd_addr, 16'h0012); chk("t1_empty_pre", q.inst_empty, 1);
    tick(); @(negedge clk); chk("t1_en_off", q.im_rd_en, 0); chk("t1_nonempty", q.inst_empty, 0);
    chk("t1_head", q.instruct, word(16'h0010));
    tick(4); @(negedge clk); chk("t1_busy", q.busy, 1); chk("t1_nodone", q.done, 0);
    tick(); q.inst_req = 1; tick(); q.inst_req = 0;
    @(negedge clk); chk("t2_head1", q.instruct, word(16'h0011));
    tick(); q.inst_req = 1; tick(); q.inst_req = 0;
    @(negedge clk); chk("t2_head2", q.instruct, word(16'h0012));
    tick(); q.inst_req = 1; tick(); q.inst_req = 0;
    @(negedge clk); chk("t2_empty", q.inst_empty, 1); chk("t2_done_early", q.done, 0);
    tick(); @(negedge clk); chk("t2_done", q.done, 1); chk("t2_idle", q.busy, 0);
    chk("t2_hold", q.instruct, word(16'h0012));
    tick(); @(negedge clk); chk("t2_done_pulse", q.done, 0);
    // T3: credit limit with a 4-entry FIFO
    tick();
    prog(16'h0100, 10);
    n = 0;
    repeat (12) begin @(negedge clk); n += int'(q.im_rd_en); tick(); end
    @(negedge clk); chk("t3_reads", n, 4); chk("t3_stalled", q.im_rd_en, 0);
    tick(); q.inst_req = 1; tick(); q.inst_req = 0;
    n = 0;
    repeat (8) begin @(negedge clk); n += int'(q.im_rd_en); tick(); end
    chk("t3_one_more", n, 1);
    drain();
    // T4: address wrap
    prog(16'hFFFE, 4);
    repeat (8) begin @(negedge clk); if (q.im_rd_en) got.push_back(q.im_rd_addr); tick(); end
    chk("t4_nreads", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("t4_addr", got[i], ex[i]);
    drain();
    // T5: push and pop in the same cycle with two entries held
    prog(16'h0020, 4);
    tick(4); q.inst_req = 1; tick(); q.inst_req = 0;
    @(negedge clk); chk("t5_head", q.instruct, word(16'h0021)); chk("t5_err", q.err_ovf, 0);
    tick(); @(negedge clk); chk("t5_hold", q.instruct, word(16'h0021));
    drain();
    // T6: reset mid-fetch, stray return, zero-length program
    prog(16'h0040, 8);
    tick(); rst = 1; tick(); rst = 0;
    @(negedge clk);
    chk("t6_busy", q.busy, 0); chk("t6_done", q.done, 0); chk("t6_err", q.err_ovf, 0);
    chk("t6_en", q.im_rd_en, 0); chk("t6_addr", q.im_rd_addr, '0);
    chk("t6_empty", q.inst_empty, 1); chk("t6_instruct", q.instruct, '0);
    tick(); stray = 1; tick(); stray = 0;
    @(negedge clk); chk("t6_err_set", q.err_ovf, 1);
    tick();
    prog(16'h0050, 0);
    @(negedge clk); chk("t6_zero_done", q.done, 1); chk("t6_zero_busy", q.busy, 0); chk("t6_zero_en", q.im_rd_en, 0);
    tick(); @(negedge clk); chk("t6_zero_pulse", q.done, 0); chk("t6_err_sticky", q.err_ovf, 1);
    tick(); rst = 1; tick(); rst = 0;
    @(negedge clk); chk("t6_err_clr", q.err_ovf, 0);
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
